// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the serial adder.
//   state_t   - controller state encoding (IDLE, RUN, DONE), 2 bits
//   cnt_width - width of the RUN-cycle counter for a given WIDTH/BITS_PER_CYCLE
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width: $clog2(WIDTH/BITS_PER_CYCLE), never less than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned bpc);
        int unsigned w;
        w = (bpc == 0) ? 0 : $clog2(width / bpc);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: gate-level 1-bit full adder.
// Ports:
//   i_a, i_b  - addend bits
//   i_cin     - carry in
//   o_sum     - sum bit
//   o_cout    - carry out
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_axb;

    assign w_axb  = i_a ^ i_b;
    assign o_sum  = w_axb ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_axb);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, BITS_PER_CYCLE bits per cycle, LSB first,
// with valid/ready handshakes on the operand and result sides.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a-b.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - operand handshake (a, b, c_in [, sub])
//   out_valid / out_ready- result handshake (sum, c_out, ovf)
//   sum                  - a+b+c_in mod 2^WIDTH
//   c_out                - carry out of bit WIDTH-1
//   ovf                  - signed overflow (carry into MSB ^ carry out of MSB)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned BPC   = BITS_PER_CYCLE;
    localparam int unsigned N     = WIDTH / BPC;
    localparam int unsigned CNT_W = cnt_width(WIDTH, BPC);

    generate
        if ((WIDTH < 2) || (BPC == 0) || ((WIDTH % BPC) != 0)) begin : g_bad_param
            $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_c_out;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_b_in;
    logic               w_c_in;
    logic [BPC-1:0]     w_chain_sum;
    logic [BPC:0]       w_carry;
    logic [WIDTH-1:0]   w_acc_nxt;

    // Operand conditioning: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : c_in;
`else
    assign w_b_in = b;
    assign w_c_in = c_in;
`endif

    // Ripple chain of full-adder cells over the low BPC bits.
    assign w_carry[0] = r_carry;
    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_cell
            fa_cell u_fa (
                .i_a   (r_a[gi]),
                .i_b   (r_b[gi]),
                .i_cin (w_carry[gi]),
                .o_sum (w_chain_sum[gi]),
                .o_cout(w_carry[gi+1])
            );
        end
    endgenerate

    // Chain result enters the accumulator at the MSB end.
    generate
        if (BPC == WIDTH) begin : g_acc_full
            assign w_acc_nxt = w_chain_sum;
        end else begin : g_acc_shift
            assign w_acc_nxt = {w_chain_sum, r_acc[WIDTH-1:BPC]};
        end
    endgenerate

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = (r_cnt == CNT_W'(N - 1));
        unique case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_in_ready_nxt  = (w_state_nxt == IDLE);
        w_out_valid_nxt = (w_state_nxt == DONE);
    end

    // Datapath: operand shift registers, carry flop, counter, result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> BPC;
            r_b     <= r_b >> BPC;
            r_acc   <= w_acc_nxt;
            r_carry <= w_carry[BPC];
            r_cnt   <= r_cnt + CNT_W'(1);
            // On the final cycle the top cell is the MSB, so its carry-in feeds ovf.
            if (w_last) begin
                r_sum   <= w_acc_nxt;
                r_c_out <= w_carry[BPC];
                r_ovf   <= w_carry[BPC] ^ w_carry[BPC-1];
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Sequential, parametrised successor to the team's single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in over multiple cycles.
- Each cycle, a chain of BITS_PER_CYCLE full-adder cells processes BITS_PER_CYCLE bits, LSB first.
- Valid/ready handshakes on input and output, so it drops into streaming datapaths where area matters more than latency.

Parameters:
- WIDTH, 8: operand and sum width in bits; must be >= 2.
- BITS_PER_CYCLE, 1: bits added per RUN cycle; must divide WIDTH exactly (elaboration-time check, $error on violation).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, a+b+c_in mod 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0; internal shift registers, carry flop and counter cleared. Reset wins over every other event, including mid-RUN and mid-DONE; partial results are discarded.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a, b into shift registers; latch c_in into the carry flop; cycle counter=0; go to RUN.
- RUN: in_ready=0.
  - Each cycle, the cell chain adds the low BITS_PER_CYCLE bits of the A/B registers plus the carry flop.
  - Result bits shift into the sum register from the MSB end; A/B shift right by BITS_PER_CYCLE; the carry flop takes the chain carry-out.
  - Carry into the MSB cell is captured on the final cycle for ovf.
  - After N=WIDTH/BITS_PER_CYCLE cycles, go to DONE.
- DONE: out_valid=1; sum, c_out, ovf are stable and held while out_ready=0. in_ready=0 and in_valid is ignored.
  - On out_valid&&out_ready: go to IDLE. out_valid drops the next cycle.
- Latency: input handshake at edge k -> out_valid=1 after edge k+N. Throughput is one result per N+2 cycles minimum (no IDLE/DONE overlap).
- Outputs are registered; no combinational path from in_valid or out_ready to any output.
- sum, c_out, ovf keep their last values in IDLE until the next result is written at the end of RUN.
- Wrap-around: carry beyond bit WIDTH-1 goes only to c_out.
- Simultaneous rst and handshake: reset applies.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined: extra input port sub (1 bit), sampled with the input handshake.
  - sub=1 stores ~b and forces the initial carry to 1 (c_in ignored), so sum=a-b mod 2^WIDTH.
  - c_out=1 means no borrow; ovf is the signed subtraction overflow.
- Undefined: no sub port; add only. Port list and behaviour are exactly as above.

Decomposition:
- Shared package serial_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2-bit encoding;
  - the function computing the counter width, $clog2(WIDTH/BITS_PER_CYCLE) with a minimum of 1.
- One sub-module, fa_cell: a gate-level 1-bit full adder (a, b, cin -> sum, cout).
  - Instantiated BITS_PER_CYCLE times in a generate loop as a ripple chain.
  - The chain exposes the carry into its top cell for ovf.

Test Plan:
- WIDTH=8, B=1: a=0xFF, b=0x01, c_in=0 -> out_valid exactly 8 cycles after the handshake; sum=0x00, c_out=1, ovf=0.
- WIDTH=8, B=1: a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, ovf=1. Then a=0x80, b=0x80, c_in=1 -> sum=0x01, c_out=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum/c_out/ovf unchanged and in_ready=0 throughout. Release -> IDLE, then the new operands are accepted.
- Reset mid-operation: assert rst on RUN cycle 3 -> next cycle state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0. A following 0x12+0x34 gives 0x46.
- WIDTH=8, B=4: a=0xA5, b=0x5A, c_in=1 -> latency 2, sum=0x00, c_out=1, ovf=0. Also randomised 1000 vectors against a behavioural a+b+c_in model.
- With SERIAL_ADDER_SUB_EN, WIDTH=8, B=1: sub=1, a=0x05, b=0x07 -> sum=0xFE, c_out=0, ovf=0. sub=1, a=0x80, b=0x01 -> sum=0x7F, c_out=1, ovf=1.
